ball_controller: RTL and testbench

- Sequences one Pong ball across the 160x120 playfield: serve, per-tick motion, wall reflection, paddle bounce, miss detection and scoring.
- Paddle bounce uses a 10-section trajectory table at speed 80 px/s.
- Sits between the paddle-movement logic (supplies paddle tops) and the VGA drawing FSM (consumes ball position).
- Owns the game state machine and the score counters.

---
 rtl/ball_controller.sv | 245 ++++++++++++++++++++++++
 tb/tb_ball_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_controller.sv
// Pong ball sequencer: serve, fixed-point motion, wall and paddle reflection,
// miss detection, scoring and the game state machine.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   enable                 run gate; low freezes all state
//   step_tick, serve       motion tick pulse, serve/restart pulse
//   lpaddle_y, rpaddle_y   paddle top rows (paddles are 20 rows tall)
//   ball_x, ball_y         ball position
//   dir_x, dir_y           1 = moving left / up
//   score_l, score_r       player scores
//   hit_pulse, point_pulse one-cycle event pulses
//   state                  0 IDLE, 1 PLAY, 2 SCORED, 3 OVER
module ball_controller #(
    parameter int unsigned TICK_HZ   = 160,
    parameter int unsigned WIN_SCORE = 7,
    parameter int unsigned SCR_W     = 160,
    parameter int unsigned SCR_H     = 120
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       step_tick,
    input  logic       serve,
    input  logic [6:0] lpaddle_y,
    input  logic [6:0] rpaddle_y,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       hit_pulse,
    output logic       point_pulse,
    output logic [1:0] state
);
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned SC_W  = 4;

    localparam logic [X_W-1:0]   X_HOME  = X_W'(SCR_W / 2);
    localparam logic [Y_W-1:0]   Y_HOME  = Y_W'(SCR_H / 2);
    localparam logic [X_W-1:0]   X_LHIT  = X_W'(3);
    localparam logic [X_W-1:0]   X_RHIT  = X_W'(SCR_W - 4);
    localparam logic [X_W-1:0]   X_MAX   = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX   = Y_W'(SCR_H - 1);
    localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(TICK_HZ);
    localparam logic [ACC_W-1:0] V_X0    = ACC_W'(77);
    localparam logic [ACC_W-1:0] V_Y0    = ACC_W'(22);
    localparam logic [SC_W-1:0]  SC_WIN  = SC_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SCORED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t           cur_state, nxt_state;
    logic [ACC_W-1:0] vx, vy, acc_x, acc_y;
    logic             serve_dir;

    logic [X_W-1:0]   bx_n;
    logic [Y_W-1:0]   by_n;
    logic             dx_n, dy_n, sd_n, hit_n, pt_n;
    logic [ACC_W-1:0] vx_n, vy_n, ax_n, ay_n;
    logic [SC_W-1:0]  sl_n, sr_n;

    logic [ACC_W-1:0] sum_x, sum_y, acc_x_step, acc_y_step;
    logic             step_x, step_y, in_span;
    logic [Y_W-1:0]   paddle_top, offset;
    logic [7:0]       span_hi;
    logic [X_W-1:0]   hit_col, miss_col;
    logic [3:0]       sec;

    // Outgoing horizontal speed per paddle section (section 0 = top).
    function automatic logic [ACC_W-1:0] sec_vx(input logic [3:0] s);
        case (s)
            4'd0, 4'd9: sec_vx = ACC_W'(22);
            4'd1, 4'd8: sec_vx = ACC_W'(40);
            4'd2, 4'd7: sec_vx = ACC_W'(57);
            4'd3, 4'd6: sec_vx = ACC_W'(69);
            default:    sec_vx = ACC_W'(77);
        endcase
    endfunction

    // Outgoing vertical speed per paddle section.
    function automatic logic [ACC_W-1:0] sec_vy(input logic [3:0] s);
        case (s)
            4'd0, 4'd9: sec_vy = ACC_W'(77);
            4'd1, 4'd8: sec_vy = ACC_W'(69);
            4'd2, 4'd7: sec_vy = ACC_W'(56);
            4'd3, 4'd6: sec_vy = ACC_W'(40);
            default:    sec_vy = ACC_W'(22);
        endcase
    endfunction

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        sat_inc = (v == SC_WIN) ? v : v + SC_W'(1);
    endfunction

    // Motion accumulators and paddle geometry for the approaching side.
    always_comb begin
        sum_x      = acc_x + vx;
        sum_y      = acc_y + vy;
        step_x     = (sum_x >= ACC_MOD);
        step_y     = (sum_y >= ACC_MOD);
        acc_x_step = step_x ? sum_x - ACC_MOD : sum_x;
        acc_y_step = step_y ? sum_y - ACC_MOD : sum_y;
        paddle_top = dir_x ? lpaddle_y : rpaddle_y;
        hit_col    = dir_x ? X_LHIT : X_RHIT;
        miss_col   = dir_x ? '0 : X_MAX;
        span_hi    = {1'b0, paddle_top} + 8'd19;
        in_span    = (ball_y >= paddle_top) && ({1'b0, ball_y} <= span_hi);
        // Only meaningful when in_span holds; wraps otherwise.
        offset     = ball_y - paddle_top;
        sec        = 4'(offset >> 1);
    end

    // Next-state and next-datapath logic.
    always_comb begin
        nxt_state = cur_state;
        bx_n      = ball_x;
        by_n      = ball_y;
        dx_n      = dir_x;
        dy_n      = dir_y;
        vx_n      = vx;
        vy_n      = vy;
        ax_n      = acc_x;
        ay_n      = acc_y;
        sl_n      = score_l;
        sr_n      = score_r;
        sd_n      = serve_dir;
        hit_n     = 1'b0;
        pt_n      = 1'b0;
        if (enable) begin
            case (cur_state)
                ST_IDLE: begin
                    bx_n = X_HOME;
                    by_n = Y_HOME;
                    if (serve) begin
                        dx_n      = serve_dir;
                        dy_n      = 1'b0;
                        vx_n      = V_X0;
                        vy_n      = V_Y0;
                        ax_n      = '0;
                        ay_n      = '0;
                        nxt_state = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (step_tick) begin
                        ax_n = acc_x_step;
                        ay_n = acc_y_step;
                        if (step_x && ball_x == hit_col && in_span) begin
                            // Bounce: ball holds this tick, new trajectory from section.
                            dx_n  = ~dir_x;
                            vx_n  = sec_vx(sec);
                            vy_n  = sec_vy(sec);
                            dy_n  = (sec <= 4'd4);
                            ax_n  = '0;
                            ay_n  = '0;
                            hit_n = 1'b1;
                        end else if (step_x && ball_x == miss_col) begin
                            if (dir_x) begin
                                sr_n = sat_inc(score_r);
                                sd_n = 1'b1;
                            end else begin
                                sl_n = sat_inc(score_l);
                                sd_n = 1'b0;
                            end
                            pt_n      = 1'b1;
                            nxt_state = ST_SCORED;
                        end else begin
                            if (step_x) begin
                                bx_n = dir_x ? ball_x - 8'd1 : ball_x + 8'd1;
                            end
                            if (step_y) begin
                                if ((dir_y && ball_y == '0) || (!dir_y && ball_y == Y_MAX)) begin
                                    dy_n = ~dir_y;
                                end else begin
                                    by_n = dir_y ? ball_y - 7'd1 : ball_y + 7'd1;
                                end
                            end
                        end
                    end
                end
                ST_SCORED: begin
                    bx_n      = X_HOME;
                    by_n      = Y_HOME;
                    nxt_state = (score_l == SC_WIN || score_r == SC_WIN) ? ST_OVER : ST_IDLE;
                end
                ST_OVER: begin
                    bx_n = X_HOME;
                    by_n = Y_HOME;
                    if (serve) begin
                        sl_n      = '0;
                        sr_n      = '0;
                        sd_n      = 1'b0;
                        nxt_state = ST_IDLE;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_state   <= ST_IDLE;
            ball_x      <= X_HOME;
            ball_y      <= Y_HOME;
            dir_x       <= 1'b0;
            dir_y       <= 1'b0;
            vx          <= V_X0;
            vy          <= V_Y0;
            acc_x       <= '0;
            acc_y       <= '0;
            score_l     <= '0;
            score_r     <= '0;
            serve_dir   <= 1'b0;
            hit_pulse   <= 1'b0;
            point_pulse <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            ball_x      <= bx_n;
            ball_y      <= by_n;
            dir_x       <= dx_n;
            dir_y       <= dy_n;
            vx          <= vx_n;
            vy          <= vy_n;
            acc_x       <= ax_n;
            acc_y       <= ay_n;
            score_l     <= sl_n;
            score_r     <= sr_n;
            serve_dir   <= sd_n;
            hit_pulse   <= hit_n;
            point_pulse <= pt_n;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_ball_controller.sv
// Self-checking bench for ball_controller: an integer game model is advanced on
// every clock and compared with the DUT each cycle, plus hand-computed pins.
module tb_ball_controller;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b1;
    logic       step_tick = 1'b0;
    logic       serve = 1'b0;
    logic [6:0] lpaddle_y = 7'd0;
    logic [6:0] rpaddle_y = 7'd0;
    logic [7:0] ball_x;
    logic [6:0] ball_y;
    logic       dir_x, dir_y, hit_pulse, point_pulse;
    logic [3:0] score_l, score_r;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    ball_controller dut (
        .clk(clk), .resetn(resetn), .enable(enable), .step_tick(step_tick),
        .serve(serve), .lpaddle_y(lpaddle_y), .rpaddle_y(rpaddle_y),
        .ball_x(ball_x), .ball_y(ball_y), .dir_x(dir_x), .dir_y(dir_y),
        .score_l(score_l), .score_r(score_r), .hit_pulse(hit_pulse),
        .point_pulse(point_pulse), .state(state)
    );

    always #5 clk = ~clk;

    // Game model in plain integers: direction as +/-1, states 0..3.
    int m_st, m_x, m_y, m_vx, m_vy, m_dx, m_dy, m_ax, m_ay;
    int m_sl, m_sr, m_sd, m_hit, m_pt;
    int vx_tab [10] = '{22, 40, 57, 69, 77, 77, 69, 57, 40, 22};
    int vy_tab [10] = '{77, 69, 56, 40, 22, 22, 40, 56, 69, 77};

    task automatic model_reset();
        m_st = 0; m_x = 80; m_y = 60; m_vx = 77; m_vy = 22; m_dx = 0; m_dy = 0;
        m_ax = 0; m_ay = 0; m_sl = 0; m_sr = 0; m_sd = 0; m_hit = 0; m_pt = 0;
    endtask

    task automatic model_clock();
        int sx, sy, top, s;
        bit xdue, ydue;
        m_hit = 0;
        m_pt  = 0;
        if (!enable) return;
        if (m_st == 0) begin
            if (serve) begin
                m_dx = m_sd; m_dy = 0; m_vx = 77; m_vy = 22; m_ax = 0; m_ay = 0; m_st = 1;
            end
        end else if (m_st == 1) begin
            if (step_tick) begin
                sx = m_ax + m_vx;
                sy = m_ay + m_vy;
                xdue = (sx >= 160);
                ydue = (sy >= 160);
                m_ax = xdue ? sx - 160 : sx;
                m_ay = ydue ? sy - 160 : sy;
                top = m_dx ? int'(lpaddle_y) : int'(rpaddle_y);
                if (xdue && m_x == (m_dx ? 3 : 156) && m_y >= top && m_y < top + 20) begin
                    s = (m_y - top) / 2;
                    m_vx = vx_tab[s];
                    m_vy = vy_tab[s];
                    m_dy = (s <= 4) ? 1 : 0;
                    m_dx = 1 - m_dx;
                    m_ax = 0; m_ay = 0; m_hit = 1;
                end else if (xdue && m_x == (m_dx ? 0 : 159)) begin
                    if (m_dx) begin m_sr = (m_sr < 7) ? m_sr + 1 : 7; m_sd = 1; end
                    else      begin m_sl = (m_sl < 7) ? m_sl + 1 : 7; m_sd = 0; end
                    m_pt = 1;
                    m_st = 2;
                end else begin
                    if (xdue) m_x = m_x + (m_dx ? -1 : 1);
                    if (ydue) begin
                        if ((m_dy && m_y == 0) || (!m_dy && m_y == 119)) m_dy = 1 - m_dy;
                        else m_y = m_y + (m_dy ? -1 : 1);
                    end
                end
            end
        end else if (m_st == 2) begin
            m_x = 80; m_y = 60;
            m_st = (m_sl == 7 || m_sr == 7) ? 3 : 0;
        end else begin
            if (serve) begin m_sl = 0; m_sr = 0; m_sd = 0; m_st = 0; end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else model_clock();
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            tests++;
            if (!(ball_x == 8'(m_x) && ball_y == 7'(m_y) && dir_x == 1'(m_dx) &&
                  dir_y == 1'(m_dy) && score_l == 4'(m_sl) && score_r == 4'(m_sr) &&
                  hit_pulse == 1'(m_hit) && point_pulse == 1'(m_pt) && state == 2'(m_st))) begin
                fails++;
                $display("FAIL cycle_model t=%0t got x=%0d y=%0d dx=%0d dy=%0d sl=%0d sr=%0d hit=%0d pt=%0d st=%0d want x=%0d y=%0d dx=%0d dy=%0d sl=%0d sr=%0d hit=%0d pt=%0d st=%0d",
                         $time, ball_x, ball_y, dir_x, dir_y, score_l, score_r, hit_pulse,
                         point_pulse, state, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_hit, m_pt, m_st);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); step_tick = 1'b1;
        @(negedge clk); step_tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_serve();
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_x", int'(ball_x), 80);
        check("rst_y", int'(ball_y), 60);
        check("rst_dirs", int'({dir_x, dir_y}), 0);
        check("rst_scores", int'({score_l, score_r}), 0);
        check("rst_pulses", int'({hit_pulse, point_pulse}), 0);
        resetn = 1'b1;

        // Serve coinciding with a tick: serve only.
        @(negedge clk); serve = 1'b1; step_tick = 1'b1;
        @(negedge clk); serve = 1'b0; step_tick = 1'b0;
        check("serve_state", int'(state), 1);
        check("serve_dir_x", int'(dir_x), 0);
        check("serve_x", int'(ball_x), 80);

        // Right paddle far away: 160 ticks move 77 px right, 22 px down.
        tick_n(160);
        check("run_x", int'(ball_x), 157);
        check("run_y", int'(ball_y), 82);
        check("run_dir_y", int'(dir_y), 0);
        tick_n(7);
        check("miss_point_pulse", int'(point_pulse), 1);
        check("miss_score_l", int'(score_l), 1);
        check("miss_state", int'(state), 2);
        check("miss_x_hold", int'(ball_x), 159);
        @(negedge clk);
        check("after_scored_state", int'(state), 0);
        check("after_scored_x", int'(ball_x), 80);
        check("after_scored_y", int'(ball_y), 60);
        check("after_scored_pulse", int'(point_pulse), 0);

        // Left player keeps scoring up to the winning score.
        for (int r = 2; r <= 7; r++) begin
            do_serve();
            if (r == 2) check("reserve_dir_x", int'(dir_x), 0);
            tick_n(167);
            check("round_point", int'(point_pulse), 1);
            @(negedge clk);
        end
        check("win_score_l", int'(score_l), 7);
        check("win_state", int'(state), 3);
        tick_n(5);
        check("over_hold_state", int'(state), 3);
        check("over_hold_score", int'(score_l), 7);
        do_serve();
        check("restart_score_l", int'(score_l), 0);
        check("restart_state", int'(state), 0);
        do_serve();
        check("replay_state", int'(state), 1);

        // Right paddle bounce at y=81 with top 76: section 2.
        rpaddle_y = 7'd76;
        lpaddle_y = 7'd100;
        tick_n(160);
        check("hit_pulse", int'(hit_pulse), 1);
        check("hit_x", int'(ball_x), 156);
        check("hit_y", int'(ball_y), 81);
        check("hit_dir_x", int'(dir_x), 1);
        check("hit_dir_y", int'(dir_y), 1);
        @(negedge clk);
        check("hit_pulse_drop", int'(hit_pulse), 0);

        // Top wall: vy=56 reaches y=0 at tick 232, wall tick at 235, y=1 at 238.
        tick_n(234);
        check("wall_pre_y", int'(ball_y), 0);
        check("wall_pre_dir", int'(dir_y), 1);
        tick_n(1);
        check("wall_y_hold", int'(ball_y), 0);
        check("wall_dir_flip", int'(dir_y), 0);
        check("wall_x", int'(ball_x), 73);
        tick_n(3);
        check("wall_next_y", int'(ball_y), 1);

        // Left paddle out of reach: ball misses on the left.
        n = 0;
        while (point_pulse !== 1'b1 && n < 400) begin tick(); n++; end
        check("left_miss_seen", int'(point_pulse), 1);
        check("left_miss_score_r", int'(score_r), 1);
        @(negedge clk);
        do_serve();
        check("serve_toward_loser", int'(dir_x), 1);

        // Asynchronous reset mid-flight.
        tick_n(20);
        #3 resetn = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_x", int'(ball_x), 80);
        check("async_rst_score_r", int'(score_r), 0);
        @(negedge clk); resetn = 1'b1;

        // Enable gating preserves position and accumulators.
        do_serve();
        tick_n(30);
        check("pre_gate_x", int'(ball_x), 94);
        check("pre_gate_y", int'(ball_y), 64);
        enable = 1'b0;
        tick_n(50);
        do_serve();
        check("gated_x", int'(ball_x), 94);
        check("gated_y", int'(ball_y), 64);
        check("gated_state", int'(state), 1);
        enable = 1'b1;
        tick_n(2);
        check("resume_x", int'(ball_x), 95);
        check("resume_y", int'(ball_y), 64);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
